// File: rtl/uart_tx_frame_ctrl_if.sv
// Byte-input handshake for the UART Tx framing controller.
//   tx_data  : byte to transmit (master -> slave)
//   tx_valid : tx_data valid     (master -> slave)
//   tx_ready : holding register empty (slave -> master); a transfer
//              happens when tx_valid && tx_ready at a rising edge.
interface uart_tx_frame_ctrl_if;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART Tx framing controller: buffers one byte, builds a 10-bit frame
// (start 0, data LSB-first, stop 1), shifts it onto txd on the baud
// counter's shift_en pulses and enables that counter while sending.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   tx_if         : byte handshake (slave side, tx_ready from holding reg)
//   shift_en_i    : bit-period-end pulse from the baud counter
//   tx_done_i     : end-of-frame pulse, coincident with the 10th shift_en
//   bps_cnt_en_o  : baud counter enable
//   txd_o         : serial line, idles high
//   tx_busy_o     : high while sending or in the inter-frame gap
//   frame_err_o   : one-cycle pulse on a counter/controller bit-count mismatch
module uart_tx_frame_ctrl #(
    parameter int unsigned IDLE_GAP = 1  // must be >= 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_frame_ctrl_if.slave  tx_if,
    input  logic                 shift_en_i,
    input  logic                 tx_done_i,
    output logic                 bps_cnt_en_o,
    output logic                 txd_o,
    output logic                 tx_busy_o,
    output logic                 frame_err_o
);

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned FRAME_W  = DATA_W + 2;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LAST_IDX = FRAME_W - 1;
    localparam int unsigned GAP_W    = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_e;

    state_e              state_q;
    logic                hold_valid_q;
    logic [DATA_W-1:0]   hold_data_q;
    logic [FRAME_W-1:0]  shreg_q;
    logic [IDX_W-1:0]    bit_idx_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic                bps_cnt_en_q;
    logic                tx_busy_q;
    logic                frame_err_q;

    logic accept;
    logic last_bit;
    logic end_ok;
    logic advance;
    logic count_err;

    assign accept   = tx_if.tx_valid && !hold_valid_q;
    assign last_bit = (bit_idx_q == IDX_W'(LAST_IDX));

    // Pulse qualification while sending: normal end, bit advance, or mismatch.
    assign end_ok    = shift_en_i && tx_done_i && last_bit;
    assign advance   = shift_en_i && !tx_done_i && !last_bit;
    assign count_err = (tx_done_i && !last_bit)
                     || (shift_en_i && !tx_done_i && last_bit)
                     || (tx_done_i && !shift_en_i);

    // Frame sequencer, holding register and registered outputs.
    // shreg_q[0] is the bit on the line; it is all-ones whenever idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            shreg_q      <= '1;
            bit_idx_q    <= '0;
            gap_cnt_q    <= '0;
            bps_cnt_en_q <= 1'b0;
            tx_busy_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;

            // Cannot coincide with a load: a load needs hold_valid_q=1.
            if (accept) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= tx_if.tx_data;
            end

            case (state_q)
                S_IDLE: begin
                    shreg_q      <= '1;
                    bps_cnt_en_q <= 1'b0;
                    tx_busy_q    <= 1'b0;
                    if (hold_valid_q) begin
                        shreg_q      <= {1'b1, hold_data_q, 1'b0};
                        bps_cnt_en_q <= 1'b1;
                        tx_busy_q    <= 1'b1;
                        bit_idx_q    <= '0;
                        hold_valid_q <= 1'b0;
                        state_q      <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (count_err || end_ok) begin
                        // Errors drop the in-flight byte; the held byte survives.
                        frame_err_q  <= count_err;
                        shreg_q      <= '1;
                        bps_cnt_en_q <= 1'b0;
                        gap_cnt_q    <= '0;
                        state_q      <= S_GAP;
                    end else if (advance) begin
                        shreg_q   <= {1'b1, shreg_q[FRAME_W-1:1]};
                        bit_idx_q <= bit_idx_q + IDX_W'(1);
                    end
                end

                S_GAP: begin
                    // Hold the counter disabled so it restarts from 0.
                    shreg_q      <= '1;
                    bps_cnt_en_q <= 1'b0;
                    if (gap_cnt_q == GAP_W'(IDLE_GAP - 1)) begin
                        tx_busy_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end

                default: begin
                    shreg_q      <= '1;
                    bps_cnt_en_q <= 1'b0;
                    tx_busy_q    <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_if.tx_ready = ~hold_valid_q;
    assign txd_o          = shreg_q[0];
    assign bps_cnt_en_o   = bps_cnt_en_q;
    assign tx_busy_o      = tx_busy_q;
    assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: behavioural baud counter, a line decoder
// feeding a byte scoreboard, table-driven frame checks and hand-written
// error / reset sequences.
module tb_uart_tx_frame_ctrl;
    localparam int unsigned IDLE_GAP = 2;

    logic clk;
    logic rst;
    logic shift_en, tx_done, bps_cnt_en, txd, tx_busy, frame_err;
    logic man, m_shift, m_done, c_shift, c_done;
    logic mon_en;
    int   cur_n, cnt, nb;
    int   total, bad;
    int   fe_cnt;
    logic [8:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_tx_frame_ctrl_if tx_if ();

    uart_tx_frame_ctrl #(.IDLE_GAP(IDLE_GAP)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_if        (tx_if),
        .shift_en_i   (shift_en),
        .tx_done_i    (tx_done),
        .bps_cnt_en_o (bps_cnt_en),
        .txd_o        (txd),
        .tx_busy_o    (tx_busy),
        .frame_err_o  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign shift_en = man ? m_shift : c_shift;
    assign tx_done  = man ? m_done  : c_done;

    // Baud counter model: registered pulse every cur_n enabled cycles.
    always @(posedge clk) begin
        if (rst || !bps_cnt_en) begin
            cnt <= 0; nb <= 0; c_shift <= 1'b0; c_done <= 1'b0;
        end else begin
            c_shift <= 1'b0;
            c_done  <= 1'b0;
            cnt     <= (cnt == cur_n - 1) ? 0 : cnt + 1;
            if (cnt == cur_n - 2) begin
                c_shift <= 1'b1;
                c_done  <= (nb == 9);
                nb      <= nb + 1;
            end
        end
    end

    initial fe_cnt = 0;
    always @(negedge clk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

    // Line decoder: samples mid-bit, pushes {stop, data}.
    initial begin : decoder
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && txd === 1'b0) begin
                repeat (cur_n / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (cur_n) @(negedge clk);
                    b[i] = txd;
                end
                repeat (cur_n) @(negedge clk);
                rx_q.push_back({txd, b});
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Entry: idle at a negedge. Exit: negedge just after the load edge.
    task automatic send_byte(input logic [7:0] d);
        chk("ready when idle", tx_if.tx_ready, 1);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        chk("ready low after accept", tx_if.tx_ready, 0);
        @(negedge clk);
        chk("ready high after load", tx_if.tx_ready, 1);
    endtask

    // Hold a byte valid until accepted; exit at the negedge after acceptance.
    task automatic offer(input logic [7:0] d);
        int w;
        w = 0;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d;
        while (tx_if.tx_ready !== 1'b1 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("offer %0h ready", d), tx_if.tx_ready, 1);
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
    endtask

    // Entry: negedge after the load edge. Checks 10 bits of cur_n cycles each,
    // then the gap; exits at the first idle negedge.
    task automatic check_frame(input logic [9:0] line, input string tag);
        logic gap_ok;
        for (int i = 0; i < 10; i++) begin
            logic seen;
            logic ctl_ok;
            seen   = line[i];
            ctl_ok = 1'b1;
            for (int c = 0; c < cur_n; c++) begin
                if (txd !== line[i]) seen = txd;
                if (bps_cnt_en !== 1'b1 || tx_busy !== 1'b1 || frame_err !== 1'b0) ctl_ok = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("%s bit%0d", tag, i), seen, line[i]);
            chk($sformatf("%s ctl%0d", tag, i), ctl_ok, 1);
        end
        chk({tag, " end txd"}, txd, 1);
        chk({tag, " end bps"}, bps_cnt_en, 0);
        chk({tag, " end busy"}, tx_busy, 1);
        gap_ok = 1'b1;
        for (int g = 1; g <= IDLE_GAP; g++) begin
            @(negedge clk);
            if (txd !== 1'b1 || bps_cnt_en !== 1'b0) gap_ok = 1'b0;
            if (g < IDLE_GAP && tx_busy !== 1'b1) gap_ok = 1'b0;
        end
        chk({tag, " gap"}, gap_ok, 1);
        chk({tag, " busy fall"}, tx_busy, 0);
    endtask

    typedef struct {
        int         n;
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    initial begin : main
        vec_t tbl[4];
        logic ok;
        int   w;
        int   fe_base;

        tbl[0] = '{434, 8'hA5, 10'b1_1010_0101_0};
        tbl[1] = '{7,   8'h01, 10'b1_0000_0001_0};
        tbl[2] = '{5,   8'h80, 10'b1_1000_0000_0};
        tbl[3] = '{3,   8'h6E, 10'b1_0110_1110_0};

        total = 0; bad = 0;
        rst = 1'b1; man = 1'b0; m_shift = 1'b0; m_done = 1'b0;
        mon_en = 1'b0; cur_n = 8;
        tx_if.tx_valid = 1'b0; tx_if.tx_data = 8'h00;

        repeat (3) @(negedge clk);
        chk("reset txd", txd, 1);
        chk("reset ready", tx_if.tx_ready, 1);
        chk("reset bps", bps_cnt_en, 0);
        chk("reset busy", tx_busy, 0);
        chk("reset ferr", frame_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single frames from the table.
        for (int k = 0; k < 4; k++) begin
            cur_n = tbl[k].n;
            send_byte(tbl[k].data);
            check_frame(tbl[k].line, $sformatf("tbl%0d", k));
            repeat (3) @(negedge clk);
        end

        // Back-to-back at N=434: 0x00 then 0xFF offered mid-frame.
        cur_n = 434;
        send_byte(8'h00);
        fork
            begin
                check_frame(10'b1_0000_0000_0, "b2b0");
                @(negedge clk);
                check_frame(10'b1_1111_1111_0, "b2b1");
            end
            begin
                repeat (100) @(negedge clk);
                offer(8'hFF);
                chk("b2b held ready", tx_if.tx_ready, 0);
            end
        join
        repeat (3) @(negedge clk);

        // Ready low: 0x3C offered while the holding register is full.
        cur_n = 16;
        send_byte(8'h11);
        fork
            begin
                check_frame(10'b1_0001_0001_0, "rl0");
                @(negedge clk);
                check_frame(10'b1_0010_0010_0, "rl1");
                @(negedge clk);
                check_frame(10'b1_0011_1100_0, "rl2");
            end
            begin
                repeat (20) @(negedge clk);
                offer(8'h22);
                tx_if.tx_valid = 1'b1;
                tx_if.tx_data  = 8'h3C;
                ok = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    if (tx_if.tx_ready !== 1'b0) ok = 1'b0;
                    @(negedge clk);
                end
                chk("ready low while full", ok, 1);
                offer(8'h3C);
            end
        join
        repeat (3) @(negedge clk);

        // Early tx_done after 5 shifts, with a byte held.
        cur_n = 4;
        man = 1'b1;
        send_byte(8'h5A);
        offer(8'hC3);
        for (int s = 0; s < 5; s++) begin
            m_shift = 1'b1;
            @(negedge clk);
            m_shift = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("early txd bit5", txd, 1);
        chk("early no ferr yet", frame_err, 0);
        m_shift = 1'b1; m_done = 1'b1;
        @(negedge clk);
        m_shift = 1'b0; m_done = 1'b0; man = 1'b0;
        chk("early ferr", frame_err, 1);
        chk("early txd", txd, 1);
        chk("early bps", bps_cnt_en, 0);
        chk("early busy gap", tx_busy, 1);
        @(negedge clk);
        chk("early ferr width", frame_err, 0);
        repeat (IDLE_GAP - 1) @(negedge clk);
        chk("early idle busy", tx_busy, 0);
        chk("early idle txd", txd, 1);
        @(negedge clk);
        check_frame(10'b1_1100_0011_0, "held");
        repeat (3) @(negedge clk);

        // Missing tx_done: 10 shift pulses without tx_done.
        man = 1'b1;
        send_byte(8'h0F);
        ok = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            if (s == 10) begin
                chk("miss stop bit", txd, 1);
                chk("miss bps before", bps_cnt_en, 1);
            end
            m_shift = 1'b1;
            @(negedge clk);
            m_shift = 1'b0;
            if (s < 10) begin
                if (frame_err !== 1'b0) ok = 1'b0;
                @(negedge clk);
            end
        end
        chk("miss no early ferr", ok, 1);
        chk("miss ferr", frame_err, 1);
        chk("miss txd", txd, 1);
        chk("miss bps", bps_cnt_en, 0);
        @(negedge clk);
        chk("miss ferr width", frame_err, 0);
        repeat (IDLE_GAP - 1) @(negedge clk);
        chk("miss idle busy", tx_busy, 0);

        // tx_done without shift_en.
        send_byte(8'h55);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        chk("lone done ferr", frame_err, 1);
        chk("lone done txd", txd, 1);
        @(negedge clk);
        repeat (IDLE_GAP - 1) @(negedge clk);
        chk("lone done idle", tx_busy, 0);

        // Pulses in IDLE are ignored.
        m_shift = 1'b1; m_done = 1'b1;
        @(negedge clk);
        m_shift = 1'b0; m_done = 1'b0;
        chk("idle pulse ferr", frame_err, 0);
        chk("idle pulse busy", tx_busy, 0);
        chk("idle pulse txd", txd, 1);
        man = 1'b0;
        @(negedge clk);

        // Reset mid-frame at bit 4 with a byte held.
        cur_n = 8;
        send_byte(8'h96);
        offer(8'h77);
        repeat (4 * 8) @(negedge clk);
        rst = 1'b1;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'hEE;
        @(negedge clk);
        chk("rst txd", txd, 1);
        chk("rst ready", tx_if.tx_ready, 1);
        chk("rst bps", bps_cnt_en, 0);
        chk("rst busy", tx_busy, 0);
        chk("rst ferr", frame_err, 0);
        rst = 1'b0;
        tx_if.tx_valid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
        end
        chk("rst no further frame", ok, 1);

        // Randomized traffic against the byte scoreboard.
        cur_n   = 6;
        mon_en  = 1'b1;
        fe_base = fe_cnt;
        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            repeat ($urandom_range(0, 25)) @(negedge clk);
            d = 8'($urandom);
            offer(d);
            exp_q.push_back(d);
        end
        w = 0;
        while (rx_q.size() < 24 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("rand byte count", rx_q.size(), 24);
        for (int k = 0; k < 24; k++) begin
            if (k < rx_q.size())
                chk($sformatf("rand byte %0d", k), rx_q[k], {1'b1, exp_q[k]});
        end
        chk("rand no ferr", fe_cnt - fe_base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
